alu_cmd_sequencer: RTL and testbench

//   Initiator side of the combinational ALU port (operation/operand1/operand2 -> result).

---
 rtl/alu_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Initiator side of a combinational ALU port. Accepts
//            register-based commands on a valid/ready stream. Reads operands
//            from an internal register file and drives the ALU for one cycle.
//            Writes the result back and returns it on a valid/ready response
//            stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_op/rd/rs1/rs2/imm_en/imm    command fields
//   wr_en/wr_addr/wr_data           host preload of the register file (idle only)
//   alu_operation/operand1/operand2 registered drive to the ALU
//   alu_result                      combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_rd/rsp_err         response fields
//   busy                            high whenever not in IDLE
// ============================================================================
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int NREG  = 8,    // must equal 2**AW
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_rd,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] LAST_LEGAL_OP = 4'd9;

  state_t state;
  state_t state_next;

  // Latched command fields
  logic [3:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs1_q;
  logic [AW-1:0]    rs2_q;
  logic             imm_en_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] regs [NREG];

  logic cmd_fire;
  logic illegal;
  logic preload;
  logic writeback;

  // cmd_ready depends on state only, never on cmd_valid
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign illegal   = (op_q > LAST_LEGAL_OP);

  // Preload and writeback can never collide: preload happens only in IDLE,
  // writeback only in EXEC.
  assign preload   = wr_en && !busy && (wr_addr != '0);
  assign writeback = (state == EXEC) && !illegal && (rd_q != '0);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else if (cmd_fire) begin
      op_q     <= cmd_op;
      rd_q     <= cmd_rd;
      rs1_q    <= cmd_rs1;
      rs2_q    <= cmd_rs2;
      imm_en_q <= cmd_imm_en;
      imm_q    <= cmd_imm;
    end
  end

  // --------------------------------------------------------------------------
  // Register file. Entry 0 is never written, so it always reads as zero.
  // A preload in the accept cycle lands before READ, so the command sees it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (preload) begin
      regs[wr_addr] <= wr_data;
    end else if (writeback) begin
      regs[rd_q] <= alu_result;
    end
  end

  // --------------------------------------------------------------------------
  // ALU drive: registered in READ so it is stable for the whole EXEC cycle.
  // Illegal opcodes present operation 0 to the ALU.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_operation <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
    end else if (state == READ) begin
      alu_operation <= illegal ? 4'd0 : op_q;
      alu_operand1  <= regs[rs1_q];
      alu_operand2  <= imm_en_q ? imm_q : regs[rs2_q];
    end
  end

  // --------------------------------------------------------------------------
  // Response: loaded in EXEC, held until the consumer accepts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= illegal ? '0 : alu_result;
      rsp_rd    <= rd_q;
      rsp_err   <= illegal;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Self-checking bench for alu_cmd_sequencer. Plays the role of the
//            combinational ALU and keeps a register-file model of its own.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_imm_en;
  logic [31:0] cmd_imm;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  alu_operation;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rf [8];
  logic [31:0] got;

  alu_cmd_sequencer #(.WIDTH(32), .NREG(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU semantics from the opcode table
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, a < b};
      4'd9: return {31'd0, a > b};
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_operation, alu_operand1, alu_operand2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr != 0) model_rf[addr] = data;
  endtask

  // Issues one command, checks latency, ALU drive, response and hold behaviour.
  // A simultaneous preload may accompany acceptance; during the hold phase
  // busy-time writes are attempted and must be ignored.
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                        input logic [31:0] imm, input int hold,
                        input logic pre_en, input logic [2:0] pre_addr, input logic [31:0] pre_data,
                        output logic [31:0] data_out);
    logic [31:0] a, b, exp;
    logic        bad;
    check({tag, ".cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = imm_en; cmd_imm = imm;
    wr_en = pre_en; wr_addr = pre_addr; wr_data = pre_data;
    if (pre_en && pre_addr != 0) model_rf[pre_addr] = pre_data;
    bad = (op > 4'd9);
    a   = model_rf[rs1];
    b   = imm_en ? imm : model_rf[rs2];
    exp = bad ? 32'd0 : alu_fn(op, a, b);
    tick();                                   // accept edge
    cmd_valid = 1'b0; wr_en = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".rsp_valid_c1"}, {31'd0, rsp_valid}, 32'd0);
    tick();                                   // operands registered
    check({tag, ".rsp_valid_c2"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".alu_op"}, {28'd0, alu_operation}, bad ? 32'd0 : {28'd0, op});
    check({tag, ".alu_a"}, alu_operand1, a);
    check({tag, ".alu_b"}, alu_operand2, b);
    tick();                                   // result captured
    check({tag, ".rsp_valid_c3"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".rsp_data"}, rsp_data, exp);
    check({tag, ".rsp_rd"}, {29'd0, rsp_rd}, {29'd0, rd});
    check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, bad});
    if (!bad && rd != 0) model_rf[rd] = exp;
    data_out = rsp_data;
    for (int h = 0; h < hold; h++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 3'($urandom_range(1, 7)); wr_data = $urandom;
      tick();
      wr_en = 1'b0;
      check({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".hold_data"}, rsp_data, exp);
      check({tag, ".hold_ready"}, {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".back_idle"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, ".rsp_dropped"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic read_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
    logic [31:0] d;
    do_cmd(tag, 4'd0, 3'd0, r, 3'd0, 1'b1, 32'd0, 0, 1'b0, 3'd0, 32'd0, d);
    check({tag, ".value"}, d, exp);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("reset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset.rsp_data", rsp_data, 32'd0);
    check("reset.alu_op", {28'd0, alu_operation}, 32'd0);
    check("reset.alu_a", alu_operand1, 32'd0);

    // 1. basic add with writeback
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd3);
    do_cmd("t1.add", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("t1.sum", got, 32'd8);
    read_reg("t1.r3", 3'd3, 32'd8);

    // 2. arithmetic and logical right shifts with immediate
    preload(3'd1, 32'h8000_0000);
    do_cmd("t2.shra", 4'd7, 3'd4, 3'd1, 3'd0, 1'b1, 32'd4, 0, 1'b0, 3'd0, 32'd0, got);
    check("t2.shra_val", got, 32'hF800_0000);
    do_cmd("t2.shr", 4'd6, 3'd4, 3'd1, 3'd0, 1'b1, 32'd4, 0, 1'b0, 3'd0, 32'd0, got);
    check("t2.shr_val", got, 32'h0800_0000);

    // 3. illegal opcode: error, no writeback
    do_cmd("t3.ill", 4'd12, 3'd5, 3'd1, 3'd2, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("t3.ill_data", got, 32'd0);
    read_reg("t3.r5", 3'd5, 32'd0);

    // 4. response back-pressure for 5 cycles
    do_cmd("t4.hold", 4'd4, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0, 5, 1'b0, 3'd0, 32'd0, got);

    // 5. reset while in EXEC discards the command and clears the file
    preload(3'd1, 32'd9);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0;
    cmd_imm_en = 1'b1; cmd_imm = 32'd1;
    tick();
    cmd_valid = 1'b0;
    tick();                                   // now in EXEC
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;
    check("t5.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("t5.busy", {31'd0, busy}, 32'd0);
    check("t5.rsp_data", rsp_data, 32'd0);
    read_reg("t5.r3", 3'd3, 32'd0);
    read_reg("t5.r1", 3'd1, 32'd0);

    // 6. preload in the accept cycle is seen; writes while busy are dropped
    do_cmd("t6.sub", 4'd1, 3'd2, 3'd1, 3'd0, 1'b0, 32'd0, 0, 1'b1, 3'd1, 32'd7, got);
    check("t6.sub_val", got, 32'd7);
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_imm_en = 1'b0; cmd_imm = 32'd0;
    tick();
    cmd_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'd99;
    tick(); tick(); tick();
    wr_en = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    read_reg("t6.r1", 3'd1, 32'd7);
    read_reg("t6.r2", 3'd2, 32'd7);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), $urandom);
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      do_cmd($sformatf("rnd%0d", n), op, 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 3'($urandom), $urandom, d);
    end
    for (int r = 0; r < 8; r++) read_reg($sformatf("final.r%0d", r), 3'(r), model_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
